// File: rtl/block_driver.sv
// block_driver: stacker-game block mover with bounce, hold/evaluate handshake and win/lose tracking
module block_driver #(
   parameter int          STEP_CYCLES = 4,
   parameter logic [7:0]  START_LOC   = 8'h07
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn,
   input  logic       stacked,
   output logic [2:0] lineNum,
   output logic [7:0] newBlockLoc,
   output logic       placed,
   output logic       game_over,
   output logic       win
);
   typedef enum logic [2:0] {IDLE, MOVE, HOLD, EVAL, OVER, WIN} state_t;
   localparam logic [7:0] LAST = 8'(STEP_CYCLES - 1);
   state_t     state, state_n;
   logic       dir, dir_n, bounce, placed_n, over_n, win_n;
   logic [7:0] cnt, cnt_n, loc_n, shifted;
   logic [2:0] line_n;
   // dir=1 means moving right; a bounce reverses the shift within the same step
   always_comb begin
      bounce   = dir ? newBlockLoc[0] : newBlockLoc[7];
      shifted  = (dir ^ bounce) ? newBlockLoc >> 1 : newBlockLoc << 1;
      state_n  = state;
      line_n   = lineNum;
      loc_n    = newBlockLoc;
      dir_n    = dir;
      cnt_n    = cnt;
      placed_n = 1'b0;
      over_n   = game_over;
      win_n    = win;
      case (state)
         IDLE: begin
            line_n = 3'd0;
            loc_n  = START_LOC;
            dir_n  = 1'b0;
            cnt_n  = 8'd0;
            over_n = 1'b0;
            win_n  = 1'b0;
            if (btn) state_n = MOVE;
         end
         MOVE: begin
            if (btn) state_n = HOLD;
            else if (cnt == LAST) begin
               cnt_n = 8'd0;
               loc_n = shifted;
               dir_n = dir ^ bounce;
            end else cnt_n = cnt + 8'd1;
         end
         HOLD: state_n = EVAL;
         EVAL: begin
            if (lineNum == 3'd0 || stacked) begin
               placed_n = 1'b1;
               if (lineNum == 3'd7) begin
                  state_n = WIN;
                  win_n   = 1'b1;
               end else begin
                  state_n = MOVE;
                  line_n  = lineNum + 3'd1;
                  loc_n   = START_LOC;
                  dir_n   = 1'b0;
                  cnt_n   = 8'd0;
               end
            end else begin
               state_n = OVER;
               over_n  = 1'b1;
            end
         end
         OVER, WIN: begin
            if (btn) begin
               state_n = IDLE;
               line_n  = 3'd0;
               loc_n   = START_LOC;
               dir_n   = 1'b0;
               cnt_n   = 8'd0;
               over_n  = 1'b0;
               win_n   = 1'b0;
            end
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         lineNum     <= 3'd0;
         newBlockLoc <= START_LOC;
         dir         <= 1'b0;
         cnt         <= 8'd0;
         placed      <= 1'b0;
         game_over   <= 1'b0;
         win         <= 1'b0;
      end else begin
         state       <= state_n;
         lineNum     <= line_n;
         newBlockLoc <= loc_n;
         dir         <= dir_n;
         cnt         <= cnt_n;
         placed      <= placed_n;
         game_over   <= over_n;
         win         <= win_n;
      end
   end
endmodule

// File: tb/tb_block_driver.sv
// tb_block_driver: directed-vector bench for block_driver with default parameters
module tb_block_driver;
   logic       clk = 1'b0;
   logic       rst_n, btn, stacked;
   logic [2:0] lineNum;
   logic [7:0] newBlockLoc;
   logic       placed, game_over, win;
   int         n_checks = 0, n_fail = 0, pcount = 0;
   logic [7:0] seq [7] = '{8'h0E, 8'h1C, 8'h38, 8'h70, 8'hE0, 8'h70, 8'h38};

   block_driver dut (
      .clk(clk), .rst_n(rst_n), .btn(btn), .stacked(stacked),
      .lineNum(lineNum), .newBlockLoc(newBlockLoc),
      .placed(placed), .game_over(game_over), .win(win)
   );

   always #5 clk = ~clk;
   always @(negedge clk) if (placed) pcount++;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; btn = 1'b0; stacked = 1'b0;
      tick(2);
      rst_n = 1'b1;
   endtask

   task automatic start();
      btn = 1'b1; tick(); btn = 1'b0;
   endtask

   task automatic place_ok();
      btn = 1'b1; tick(); btn = 1'b0;
      stacked = 1'b1; tick(); tick(); stacked = 1'b0;
   endtask

   initial begin
      do_reset();
      check("rst_line", 8'(lineNum), 8'h00);
      check("rst_loc", newBlockLoc, 8'h07);
      check("rst_flags", {5'd0, placed, game_over, win}, 8'h00);

      start();
      tick(3);
      check("move_hold07", newBlockLoc, 8'h07);
      tick();
      check("move_0", newBlockLoc, seq[0]);
      for (int i = 1; i < 7; i++) begin
         tick(3);
         check("move_stable", newBlockLoc, seq[i-1]);
         tick();
         check("move_step", newBlockLoc, seq[i]);
      end

      do_reset();
      start();
      tick(8);
      check("l0_at1c", newBlockLoc, 8'h1C);
      btn = 1'b1; tick(); btn = 1'b0;
      check("l0_hold_loc", newBlockLoc, 8'h1C);
      check("l0_hold_line", 8'(lineNum), 8'h00);
      tick();
      check("l0_eval_loc", newBlockLoc, 8'h1C);
      check("l0_eval_placed", 8'(placed), 8'h00);
      tick();
      check("l0_placed", 8'(placed), 8'h01);
      check("l0_line", 8'(lineNum), 8'h01);
      check("l0_loc", newBlockLoc, 8'h07);
      tick();
      check("l0_placed_pulse", 8'(placed), 8'h00);

      btn = 1'b1; tick(); btn = 1'b0;
      stacked = 1'b0; tick(); tick();
      check("miss_over", 8'(game_over), 8'h01);
      check("miss_line", 8'(lineNum), 8'h01);
      check("miss_loc", newBlockLoc, 8'h07);
      check("miss_placed", 8'(placed), 8'h00);
      tick(3);
      check("miss_held", {newBlockLoc[6:0], game_over}, 8'h0F);
      start();
      check("miss_idle_over", 8'(game_over), 8'h00);
      check("miss_idle_line", 8'(lineNum), 8'h00);

      start();
      tick(3);
      btn = 1'b1; tick();
      check("coll_frozen", newBlockLoc, 8'h07);
      tick(); btn = 1'b0;
      tick();
      check("coll_placed", 8'(placed), 8'h01);
      check("coll_line", 8'(lineNum), 8'h01);
      tick(4);
      check("noqueue_moved", newBlockLoc, 8'h0E);

      do_reset();
      start();
      pcount = 0;
      for (int l = 0; l < 8; l++) begin
         place_ok();
         check("win_line", 8'(lineNum), (l < 7) ? 8'(l + 1) : 8'd7);
      end
      tick();
      check("win_pulses", 8'(pcount), 8'd8);
      check("win_flag", 8'(win), 8'h01);
      check("win_over", 8'(game_over), 8'h00);
      start();
      check("win_idle_line", 8'(lineNum), 8'h00);
      check("win_idle_flag", 8'(win), 8'h00);

      do_reset();
      start();
      repeat (3) place_ok();
      check("r3_line", 8'(lineNum), 8'h03);
      btn = 1'b1; tick();
      rst_n = 1'b0; tick();
      rst_n = 1'b1; btn = 1'b0;
      check("r3_line0", 8'(lineNum), 8'h00);
      check("r3_loc", newBlockLoc, 8'h07);
      check("r3_flags", {5'd0, placed, game_over, win}, 8'h00);
      tick(6);
      check("r3_idle", newBlockLoc, 8'h07);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/block_driver.md
BLOCK_DRIVER -- requirements
Module: block_driver

Interface
REQ-001 The block SHALL have parameter STEP_CYCLES, default 4: clock cycles per one-position move of the block (legal range 1..255).
REQ-002 The block SHALL have parameter START_LOC, default 8'h07: the 8-bit block pattern loaded at the start of every line.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port btn, input, 1 bit: place/start request, already debounced and one cycle wide.
REQ-006 The block SHALL have port stacked, input, 1 bit: comparator result, valid one cycle after the comparator samples.
REQ-007 The block SHALL have port lineNum, output, 3 bits: current line index, fed to the comparator.
REQ-008 The block SHALL have port newBlockLoc, output, 8 bits: current block pattern, fed to the comparator.
REQ-009 The block SHALL have port placed, output, 1 bit: one-cycle pulse on a successful placement.
REQ-010 The block SHALL have port game_over, output, 1 bit: level, set on a miss.
REQ-011 The block SHALL have port win, output, 1 bit: level, set after line 7 is placed successfully.

Function
REQ-012 The block SHALL implement the states IDLE, MOVE, HOLD, EVAL, OVER and WIN, encoded internally.
REQ-013 IDLE: lineNum=0, newBlockLoc=START_LOC, dir=left; btn=1 -> MOVE, with the step counter cleared.
REQ-014 MOVE: the step counter SHALL count 0..STEP_CYCLES-1; when it reaches STEP_CYCLES-1 it wraps to 0 and the pattern moves one position.
REQ-015 Move left = pattern<<1 and move right = pattern>>1, with no bits lost in either direction.
REQ-016 Bounce: if moving left with newBlockLoc[7]=1, dir SHALL flip to right and the same step SHALL shift right.
REQ-017 Bounce: if moving right with newBlockLoc[0]=1, dir SHALL flip to left and the same step SHALL shift left.
REQ-018 btn=1 in MOVE -> HOLD, with the pattern frozen; btn SHALL take priority over a step due in the same cycle, so no shift occurs.
REQ-019 HOLD SHALL last exactly 1 cycle so the comparator can sample the frozen pattern, then -> EVAL; lineNum and newBlockLoc SHALL be unchanged in HOLD.
REQ-020 EVAL success (lineNum==0, or stacked==1), lineNum<7: placed=1 for this cycle; lineNum+1 on exit; newBlockLoc=START_LOC, dir=left, step counter=0; -> MOVE.
REQ-021 EVAL success with lineNum==7: placed=1; -> WIN; lineNum SHALL stay 7 (no wrap to 0).
REQ-022 EVAL failure (lineNum!=0 and stacked==0) -> OVER; placed SHALL stay 0.
REQ-023 In EVAL, stacked SHALL be ignored when lineNum==0.
REQ-024 OVER: game_over=1; lineNum and newBlockLoc SHALL be held; btn=1 -> IDLE.
REQ-025 WIN: win=1; lineNum and newBlockLoc SHALL be held; btn=1 -> IDLE.
REQ-026 On entering IDLE, game_over and win SHALL clear.
REQ-027 btn in HOLD or EVAL SHALL be ignored and SHALL NOT be queued.
REQ-028 All outputs SHALL be registered; lineNum and newBlockLoc SHALL change only on the clk edges defined above.
REQ-029 newBlockLoc SHALL always keep popcount(START_LOC) ones, contiguous for a contiguous START_LOC.

Reset
REQ-030 rst_n=0 sampled on a rising clk edge SHALL force IDLE, lineNum=0, newBlockLoc=START_LOC, dir=left, step counter=0, placed=0, game_over=0, win=0.
REQ-031 Reset SHALL take priority over btn and over every state, including mid-HOLD and mid-EVAL; nothing SHALL take effect until the first edge with rst_n=1.

Verification
REQ-032 Move/bounce: reset, btn -> newBlockLoc steps 07,0E,1C,38,70,E0,70,38,..., changing every 4 cycles, with the bounce at E0.
REQ-033 Line 0: btn at newBlockLoc=1C, stacked forced 0 -> HOLD for 1 cycle; EVAL pulses placed=1; lineNum becomes 1 and newBlockLoc becomes 07.
REQ-034 Miss: on line 1, btn with stacked=0 in EVAL -> game_over=1, lineNum stays 1, newBlockLoc frozen; btn -> IDLE, game_over=0.
REQ-035 Win: 8 placements with stacked=1 -> placed pulses 8 times, win=1, lineNum=7; an extra btn -> IDLE, lineNum=0.
REQ-036 Collision: btn in the same cycle a step is due -> no shift; the pattern is frozen at its pre-step value.
REQ-037 Reset: rst_n=0 during HOLD on line 3 -> next edge gives IDLE, lineNum=0, newBlockLoc=07, all flags 0.
